// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: state encoding and shared widths for the reset sequencer.
package rst_seq_pkg;
  localparam int LOSS_CNT_W = 8;
  typedef enum logic [2:0] {
    RESET     = 3'd0,
    WAIT_LOCK = 3'd1,
    STRETCH   = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_e;
endpackage

// File: rtl/rst_seq_multi_if.sv
// rst_seq_multi_if: lock/software-reset inputs and domain-reset outputs of the sequencer.
interface rst_seq_multi_if import rst_seq_pkg::*; #(
  parameter int N_LOCK = 2,
  parameter int N_DOM  = 4
) ();
  logic [N_LOCK-1:0]     lock_i;
  logic                  sw_rst_i;
  logic [N_DOM-1:0]      rst_o;
  logic                  all_rdy_o;
  logic [2:0]            state_o;
  logic [LOSS_CNT_W-1:0] loss_cnt_o;
  modport master (output lock_i, sw_rst_i, input rst_o, all_rdy_o, state_o, loss_cnt_o);
  modport slave  (input lock_i, sw_rst_i, output rst_o, all_rdy_o, state_o, loss_cnt_o);
endinterface

// File: rtl/rst_sync_2ff.sv
// rst_sync_2ff: two-flop synchronizer with asynchronous clear.
module rst_sync_2ff (
  input  logic clk_i,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;
  always_ff @(posedge clk_i or posedge clr_i)
    if (clr_i) sync_q <= 2'b00;
    else sync_q <= {sync_q[0], d_i};
  assign q_o = sync_q[1];
endmodule

// File: rtl/rst_seq_multi.sv
// rst_seq_multi: debounced-lock reset sequencer with stretched, staggered domain release.
// Optional lock-loss counter built when RST_SEQ_LOSS_CNT_EN is defined.
module rst_seq_multi import rst_seq_pkg::*; #(
  parameter int N_LOCK  = 2,
  parameter int N_DOM   = 4,
  parameter int FILT    = 4,
  parameter int STRETCH = 16,
  parameter int STAGGER = 8
) (
  input logic            wb_clk_o,
  input logic            async_rst_o,
  rst_seq_multi_if.slave bus
);
  localparam int FILT_W = $clog2(FILT) + 1;
  localparam int STR_W  = $clog2(STRETCH + 1) + 1;
  localparam int REL_W  = $clog2((N_DOM - 1) * STAGGER + 1) + 1;
  logic [N_LOCK-1:0] lock_s;
  state_e            state_q;
  logic [FILT_W-1:0] filt_q;
  logic [STR_W-1:0]  str_q;
  logic [REL_W-1:0]  rel_q, rel_d;
  logic [N_DOM-1:0]  rst_q, rel_mask;
  logic              rdy_q, lock_all, loss, sw_go, filt_done, str_done, go_rel;
  for (genvar i = 0; i < N_LOCK; i++) begin : g_sync
    rst_sync_2ff u_sync (.clk_i(wb_clk_o), .clr_i(async_rst_o), .d_i(bus.lock_i[i]), .q_o(lock_s[i]));
  end
  assign lock_all  = &lock_s;
  assign loss      = !lock_all && (state_q inside {rst_seq_pkg::STRETCH, RELEASE, RUN});
  assign sw_go     = bus.sw_rst_i && (state_q inside {RELEASE, RUN});
  assign filt_done = state_q == WAIT_LOCK && lock_all && filt_q == FILT_W'(FILT - 1);
  assign str_done  = state_q == rst_seq_pkg::STRETCH && lock_all && !bus.sw_rst_i &&
                     (STRETCH == 0 || str_q == STR_W'(STRETCH - 1));
  assign go_rel    = (filt_done && STRETCH == 0) || str_done || state_q == RELEASE;
  // Cycles since rst_o[0] released; zero on the entry edge itself.
  assign rel_d = (state_q == RELEASE) ? rel_q + 1'b1 : '0;
  always_comb begin
    rel_mask = '1;
    for (int k = 0; k < N_DOM; k++) rel_mask[k] = int'(rel_d) < k * STAGGER;
  end
  always_ff @(posedge wb_clk_o or posedge async_rst_o)
    if (async_rst_o) begin
      state_q <= RESET;
      filt_q  <= '0;
      str_q   <= '0;
      rel_q   <= '0;
      rst_q   <= '1;
      rdy_q   <= 1'b0;
    end else if (loss || sw_go) begin
      state_q <= loss ? WAIT_LOCK : rst_seq_pkg::STRETCH;
      filt_q  <= '0;
      str_q   <= '0;
      rel_q   <= '0;
      rst_q   <= '1;
      rdy_q   <= 1'b0;
    end else if (go_rel) begin
      state_q <= ~|rel_mask ? RUN : RELEASE;
      filt_q  <= '0;
      str_q   <= '0;
      rel_q   <= rel_d;
      rst_q   <= rel_mask;
      rdy_q   <= ~|rel_mask;
    end else if (filt_done) begin
      state_q <= rst_seq_pkg::STRETCH;
      filt_q  <= '0;
      str_q   <= '0;
    end else begin
      case (state_q)
        RESET:                state_q <= WAIT_LOCK;
        WAIT_LOCK:            filt_q  <= lock_all ? filt_q + 1'b1 : '0;
        rst_seq_pkg::STRETCH: str_q   <= bus.sw_rst_i ? '0 : str_q + 1'b1;
        default:              ;
      endcase
    end
  assign bus.rst_o     = rst_q;
  assign bus.all_rdy_o = rdy_q;
  assign bus.state_o   = state_q;
`ifdef RST_SEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_q;
  always_ff @(posedge wb_clk_o or posedge async_rst_o)
    if (async_rst_o) loss_q <= '0;
    else if (loss && loss_q != '1) loss_q <= loss_q + 1'b1;
  assign bus.loss_cnt_o = loss_q;
`else
  assign bus.loss_cnt_o = '0;
`endif
endmodule

// File: tb/tb_rst_seq_multi.sv
// tb_rst_seq_multi: scoreboard bench for two sequencer configurations sharing one stimulus stream.
module tb_rst_seq_multi;
  import rst_seq_pkg::*;
  localparam int FILT = 4;
  typedef struct packed {
    logic [3:0] rst;
    logic       rdy;
    logic [2:0] st;
    logic [7:0] lc;
  } exp_t;
  localparam exp_t RST_EXP = '{rst: 4'hF, rdy: 1'b0, st: 3'd0, lc: 8'd0};
  int str_p [2] = '{16, 0};
  int stg_p [2] = '{8, 0};
  logic clk = 1'b0, arst = 1'b1, sw = 1'b0;
  logic [1:0] lock = 2'b00;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  rst_seq_multi_if #(.N_LOCK(2), .N_DOM(4)) b0 ();
  rst_seq_multi_if #(.N_LOCK(2), .N_DOM(4)) b1 ();
  assign b0.lock_i = lock;
  assign b1.lock_i = lock;
  assign b0.sw_rst_i = sw;
  assign b1.sw_rst_i = sw;
  rst_seq_multi #(.N_LOCK(2), .N_DOM(4), .FILT(FILT), .STRETCH(16), .STAGGER(8)) u0 (
    .wb_clk_o(clk), .async_rst_o(arst), .bus(b0));
  rst_seq_multi #(.N_LOCK(2), .N_DOM(4), .FILT(FILT), .STRETCH(0), .STAGGER(0)) u1 (
    .wb_clk_o(clk), .async_rst_o(arst), .bus(b1));
  // Reference: a timeline t counted from lock acceptance; domain k is free once t >= STRETCH + k*STAGGER.
  bit started [2], seq [2], hold [2];
  int run [2], t [2], lc [2];
  logic [1:0] l1, l2;
  bit lk_m;
  exp_t q0 [$], q1 [$];
  exp_t e0, e1;
  function automatic exp_t expect_of(int i);
    exp_t e;
    e.rst = 4'hF;
    if (seq[i] && !hold[i])
      for (int k = 0; k < 4; k++) e.rst[k] = !(t[i] >= str_p[i] + k * stg_p[i]);
    e.rdy = (e.rst == 4'h0);
    e.lc  = 8'(lc[i]);
    e.st  = !started[i] ? 3'd0 : !seq[i] ? 3'd1 : (hold[i] || t[i] < str_p[i]) ? 3'd2 : e.rdy ? 3'd4 : 3'd3;
    return e;
  endfunction
  task automatic step(int i, bit lk);
    if (!started[i]) started[i] = 1'b1;
    else if (!seq[i]) begin
      run[i] = lk ? run[i] + 1 : 0;
      if (run[i] == FILT) begin
        seq[i] = 1'b1; t[i] = 0; hold[i] = 1'b0; run[i] = 0;
      end
    end else if (!lk) begin
      seq[i] = 1'b0; run[i] = 0;
`ifdef RST_SEQ_LOSS_CNT_EN
      if (lc[i] < 255) lc[i]++;
`endif
    end else if (sw) begin
      hold[i] = 1'b1; t[i] = 0;
    end else if (hold[i]) begin
      hold[i] = 1'b0; t[i] = (str_p[i] == 0) ? 0 : 1;
    end else t[i]++;
  endtask
  always @(posedge clk) begin
    if (arst) begin
      for (int i = 0; i < 2; i++) begin
        started[i] = 1'b0; seq[i] = 1'b0; hold[i] = 1'b0; run[i] = 0; t[i] = 0; lc[i] = 0;
      end
      l1 = 2'b00; l2 = 2'b00;
    end else begin
      lk_m = &l2; l2 = l1; l1 = lock;
      step(0, lk_m);
      step(1, lk_m);
    end
    q0.push_back(expect_of(0));
    q1.push_back(expect_of(1));
  end
  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      cmp("u0_out", {b0.rst_o, b0.all_rdy_o, b0.state_o, b0.loss_cnt_o}, arst ? RST_EXP : e0);
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      cmp("u1_out", {b1.rst_o, b1.all_rdy_o, b1.state_o, b1.loss_cnt_o}, arst ? RST_EXP : e1);
    end
  end
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  function automatic bit cond(int what);
    return what == 0 ? !b0.rst_o[1] : what == 1 ? b0.state_o == 3'd4 : b0.state_o == 3'd2;
  endfunction
  task automatic wait_for(input string nm, input int what, input int budget);
    int n;
    for (n = 0; n < budget && !cond(what); n++) tick(1);
    if (n == budget) begin
      checks++; errors++;
      $display("FAIL %s timeout after %0d cycles, condition required", nm, budget);
    end
  endtask
  initial begin
    int f [6];
    tick(5);
    arst = 1'b0;
    tick(2);
    f = '{-1, -1, -1, -1, -1, -1};
    lock = 2'b11;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      for (int j = 0; j < 4; j++) if (f[j] < 0 && !b0.rst_o[j]) f[j] = k;
      if (f[4] < 0 && b0.all_rdy_o) f[4] = k;
      if (f[5] < 0 && b1.rst_o == 4'h0 && b1.all_rdy_o) f[5] = k;
    end
    #1;
    cmp("fall_rst0", 16'(f[0]), 16'd22);
    cmp("fall_rst1", 16'(f[1]), 16'd30);
    cmp("fall_rst2", 16'(f[2]), 16'd38);
    cmp("fall_rst3", 16'(f[3]), 16'd46);
    cmp("rise_rdy", 16'(f[4]), 16'd46);
    cmp("u1_all_fall", 16'(f[5]), 16'd6);
    lock = 2'b01;
    tick(1);
    lock = 2'b11;
    @(posedge clk);
    @(posedge clk);
    #1;
    cmp("loss_state", 16'(b0.state_o), 16'd1);
    cmp("loss_rst", 16'(b0.rst_o), 16'hF);
    cmp("loss_rdy", 16'(b0.all_rdy_o), 16'd0);
`ifdef RST_SEQ_LOSS_CNT_EN
    cmp("loss_cnt", 16'(b0.loss_cnt_o), 16'd1);
`else
    cmp("loss_cnt", 16'(b0.loss_cnt_o), 16'd0);
`endif
    #1;
    wait_for("wait_rst1_low", 0, 100);
    sw = 1'b1;
    @(posedge clk);
    #1;
    cmp("sw_rst", 16'(b0.rst_o), 16'hF);
    cmp("sw_state", 16'(b0.state_o), 16'd2);
    #1;
    tick(2);
    sw = 1'b0;
    tick(50);
    wait_for("wait_run", 1, 200);
    lock = 2'b00;
    tick(2);
    sw = 1'b1;
    tick(1);
    sw = 1'b0;
    cmp("sim_state", 16'(b0.state_o), 16'd1);
    lock = 2'b11;
    tick(60);
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: begin lock = 2'($urandom_range(0, 2)); tick($urandom_range(1, 3)); lock = 2'b11; end
        1: begin sw = 1'b1; tick($urandom_range(1, 4)); sw = 1'b0; end
        2: begin lock = 2'($urandom_range(0, 2)); tick(1); sw = 1'b1; tick(1); sw = 1'b0; lock = 2'b11; end
        default: ;
      endcase
      tick($urandom_range(1, 60));
    end
    lock = 2'b00;
    tick(3);
    lock = 2'b11;
    wait_for("wait_stretch", 2, 200);
    tick(3);
    arst = 1'b1;
    #1;
    cmp("arst_rst", 16'(b0.rst_o), 16'hF);
    cmp("arst_state", 16'(b0.state_o), 16'd0);
    cmp("arst_u1", 16'(b1.rst_o), 16'hF);
    #1;
    tick(2);
    arst = 1'b0;
    tick(2);
    lock = 2'b11;
    tick(3);
    lock = 2'b01;
    tick(1);
    lock = 2'b11;
    tick(60);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
